// File: rtl/mdu_pkg.sv
// Shared op-code encoding, default latencies and result type for the multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing a {hi,lo} result.
// A single magnitude divider serves both signed and unsigned divides.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output hilo_t       result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic        div_overflow;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign signed_div = (op == OP_DIV);
    assign a_mag      = a[31] ? (~a + 32'd1) : a;
    assign b_mag      = b[31] ? (~b + 32'd1) : b;

    assign div_by_zero  = is_div_op(op) && (b == 32'd0);
    assign div_overflow = signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Divisor forced to 1 on zero so the divider output is always defined; the result is discarded anyway.
    assign dividend = signed_div ? a_mag : a;
    assign divisor  = (b == 32'd0) ? 32'd1 : (signed_div ? b_mag : b);
    assign q_mag    = dividend / divisor;
    assign r_mag    = dividend % divisor;

    assign neg_q = signed_div && (a[31] ^ b[31]);
    assign neg_r = signed_div && a[31];

    always_comb begin
        quot = neg_q ? (~q_mag + 32'd1) : q_mag;
        rem  = neg_r ? (~r_mag + 32'd1) : r_mag;
        if (div_overflow) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
        end
    end

    always_comb begin
        result = '0;
        case (op)
            OP_MULT:          result = prod_s;
            OP_MULTU:         result = prod_u;
            OP_DIV, OP_DIVU:  result = '{hi: rem, lo: quot};
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: sequences a fixed-latency busy window and commits to HI/LO.
//   state | meaning
//   IDLE  | accepts mult/div starts and MTHI/MTLO writes
//   RUN   | counting down; pending result commits when the count reaches 1
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    hilo_t            pending;
    logic             pending_dbz;
    logic [31:0]      hi;
    logic [31:0]      lo;

    hilo_t            arith_result;
    logic             arith_dbz;

    mdu_arith u_arith (
        .a           (a),
        .b           (b),
        .op          (mdu_op),
        .result      (arith_result),
        .div_by_zero (arith_dbz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pending     <= '0;
            pending_dbz <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (is_start_op(mdu_op)) begin
                            pending     <= arith_result;
                            pending_dbz <= arith_dbz;
                            cnt         <= is_div_op(mdu_op) ? DIV_LOAD : MULT_LOAD;
                            state       <= ST_RUN;
                        end else if (mdu_op == OP_MTHI) begin
                            hi <= a;
                        end else if (mdu_op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_RUN: begin
                    // Any op_valid here is ignored; upstream stalls on busy.
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_IDLE;
                        if (!pending_dbz) begin
                            hi <= pending.hi;
                            lo <= pending.lo;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_RUN);
    assign rdata = (mdu_op == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: busy window, HI/LO results, ignored ops during RUN and reset abort.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] rdata;

    int checks;
    int failures;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .mdu_op   (mdu_op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        mdu_op = OP_MFHI;
        #1;
        check({tag, "_hi"}, rdata, exp_hi);
        mdu_op = OP_MFLO;
        #1;
        check({tag, "_lo"}, rdata, exp_lo);
        mdu_op = OP_NONE;
    endtask

    // Issues a start in the current cycle and checks busy across the whole window.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input int n);
        op_valid = 1'b1;
        mdu_op   = op;
        a        = va;
        b        = vb;
        #1;
        check({tag, "_busy_start"}, 32'(busy), 32'd0);
        step();
        op_valid = 1'b0;
        mdu_op   = OP_NONE;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
            step();
        end
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic write_reg(input logic [3:0] op, input logic [31:0] va);
        op_valid = 1'b1;
        mdu_op   = op;
        a        = va;
        step();
        op_valid = 1'b0;
        mdu_op   = OP_NONE;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        op_valid = 1'b0;
        mdu_op   = OP_NONE;
        a        = '0;
        b        = '0;
        step();
        step();
        reset = 1'b0;
        step();

        check("reset_busy", 32'(busy), 32'd0);
        read_hilo("reset", 32'h0, 32'h0);

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
        read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10);
        read_hilo("div_negb", 32'h0000_0001, 32'hFFFF_FFFD);

        run_op("divu", OP_DIVU, 32'd7, 32'd2, 10);
        read_hilo("divu", 32'h1, 32'h3);

        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        read_hilo("div_ovf", 32'h0, 32'h8000_0000);

        write_reg(OP_MTHI, 32'h11);
        read_hilo("mthi", 32'h11, 32'h8000_0000);
        write_reg(OP_MTLO, 32'h22);
        read_hilo("mtlo", 32'h11, 32'h22);

        run_op("div0", OP_DIV, 32'd1234, 32'd0, 10);
        read_hilo("div0", 32'h11, 32'h22);

        // MULT 3*4 with an MTHI and a second MULT presented while running.
        op_valid = 1'b1;
        mdu_op   = OP_MULT;
        a        = 32'd3;
        b        = 32'd4;
        step();
        for (int i = 1; i <= 5; i++) begin
            case (i)
                1: begin op_valid = 1'b1; mdu_op = OP_MTHI; a = 32'hAAAA; end
                2: begin op_valid = 1'b1; mdu_op = OP_MULT; a = 32'd100; b = 32'd100; end
                default: begin op_valid = 1'b0; mdu_op = OP_NONE; end
            endcase
            #1;
            check("ignore_busy_run", 32'(busy), 32'd1);
            step();
        end
        op_valid = 1'b0;
        mdu_op   = OP_NONE;
        check("ignore_busy_end", 32'(busy), 32'd0);
        read_hilo("ignore", 32'h0, 32'd12);

        // Reset during busy cycle 3 of a DIVU aborts the operation.
        op_valid = 1'b1;
        mdu_op   = OP_DIVU;
        a        = 32'd7;
        b        = 32'd2;
        step();
        op_valid = 1'b0;
        mdu_op   = OP_NONE;
        step();
        step();
        check("abort_busy_c3", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        read_hilo("abort", 32'h0, 32'h0);
        write_reg(OP_MTLO, 32'd5);
        read_hilo("abort_mtlo", 32'h0, 32'd5);
        for (int i = 0; i < 12; i++) step();
        check("abort_idle_busy", 32'(busy), 32'd0);
        read_hilo("abort_late", 32'h0, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
